// File: rtl/dut_pkg.sv
// Shared constants for the dut_core OR engine: register map and default widths.
package dut_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_FIFO_DEPTH = 2;

  localparam int ADDR_A_STATUS = 0;
  localparam int ADDR_B_STATUS = 1;
  localparam int ADDR_Y_STATUS = 2;
  localparam int ADDR_Y_DATA   = 3;
  localparam int ADDR_A_DATA   = 4;
  localparam int ADDR_B_DATA   = 5;

endpackage

// File: rtl/dut_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; push and pop may coincide.
// The caller never pushes when full, so occupancy is simply count + push - pop.
module dut_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap keeps pointers legal for any DEPTH, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/dut_core.sv
// Register-mapped A|B engine: host fills a_ff/b_ff, core pushes results into y_ff.
// Define DUT_COUNTER_SAT_EN to make counter_out saturate instead of wrapping.
module dut_core
  import dut_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_rdy,
  output logic [DATA_W-1:0] counter_out,
  output logic              a_ff_EMPTY_N
);

  logic              a_full, a_empty, b_full, b_empty, y_full, y_empty;
  logic [DATA_W-1:0] a_head, b_head, y_head;
  logic              a_push, b_push, y_pop, compute;
  logic [DATA_W-1:0] counter_q, counter_d;

  always_comb begin
    write_rdy = 1'b1;
    if (write_address == ADDR_W'(ADDR_A_DATA)) begin
      write_rdy = ~a_full;
    end else if (write_address == ADDR_W'(ADDR_B_DATA)) begin
      write_rdy = ~b_full;
    end
  end

  always_comb begin
    read_data = '0;
    read_rdy  = 1'b1;
    case (read_address)
      ADDR_W'(ADDR_A_STATUS): read_data = {{(DATA_W-1){1'b0}}, ~a_full};
      ADDR_W'(ADDR_B_STATUS): read_data = {{(DATA_W-1){1'b0}}, ~b_full};
      ADDR_W'(ADDR_Y_STATUS): read_data = {{(DATA_W-1){1'b0}}, ~y_empty};
      ADDR_W'(ADDR_Y_DATA): begin
        if (y_empty) begin
          read_rdy = 1'b0;
        end else begin
          read_data = y_head;
        end
      end
      default: read_data = '0;
    endcase
  end

  // All decisions use pre-edge full/empty, so simultaneous push/pop never over/underflows.
  assign a_push  = write_en & write_rdy & (write_address == ADDR_W'(ADDR_A_DATA));
  assign b_push  = write_en & write_rdy & (write_address == ADDR_W'(ADDR_B_DATA));
  assign y_pop   = read_en & read_rdy & (read_address == ADDR_W'(ADDR_Y_DATA));
  assign compute = ~a_empty & ~b_empty & ~y_full;

  always_comb begin
    counter_d = counter_q;
    if (compute) begin
`ifdef DUT_COUNTER_SAT_EN
      if (counter_q != '1) begin
        counter_d = counter_q + DATA_W'(1);
      end
`else
      counter_d = counter_q + DATA_W'(1);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  dut_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_a_ff (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (a_push),
    .push_data (write_data),
    .pop       (compute),
    .head      (a_head),
    .full      (a_full),
    .empty     (a_empty)
  );

  dut_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_b_ff (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (b_push),
    .push_data (write_data),
    .pop       (compute),
    .head      (b_head),
    .full      (b_full),
    .empty     (b_empty)
  );

  dut_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_y_ff (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (compute),
    .push_data (a_head | b_head),
    .pop       (y_pop),
    .head      (y_head),
    .full      (y_full),
    .empty     (y_empty)
  );

  assign counter_out  = counter_q;
  assign a_ff_EMPTY_N = ~a_empty;

endmodule

// File: tb/tb_dut_core.sv
// Self-checking bench for dut_core: directed vector table, corner sequences and
// randomized traffic checked against a queue-based model of the register map.
module tb_dut_core;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          write_rdy;
  logic [AW-1:0] read_address;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          read_rdy;
  logic [DW-1:0] counter_out;
  logic          a_ff_EMPTY_N;

  always #5 clk = ~clk;

  dut_core dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy),
    .counter_out   (counter_out),
    .a_ff_EMPTY_N  (a_ff_EMPTY_N)
  );

  // Reference model: three queues and a count of results ever produced.
  logic [DW-1:0] aq[$];
  logic [DW-1:0] bq[$];
  logic [DW-1:0] yq[$];
  int n_results = 0;
  int n_pass    = 0;
  int n_total   = 0;

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we;
    logic [AW-1:0] ra;
    logic          re;
    logic          e_wrdy;
    logic [DW-1:0] e_rdata;
    logic          e_rrdy;
    logic [DW-1:0] e_cnt;
    logic          e_aen;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] exp_counter();
`ifdef DUT_COUNTER_SAT_EN
    return (n_results > 255) ? 8'hFF : 8'(n_results);
`else
    return 8'(n_results % 256);
`endif
  endfunction

  task automatic apply(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic we,
                       input logic [AW-1:0] ra, input logic re);
    write_address = wa;
    write_data    = wd;
    write_en      = we;
    read_address  = ra;
    read_en       = re;
  endtask

  // Advance the model by the rules of one clock edge, using pre-edge occupancy.
  task automatic model_edge();
    bit pop_y, push_a, push_b, comp;
    if (!rst_n) begin
      aq.delete();
      bq.delete();
      yq.delete();
      n_results = 0;
      return;
    end
    pop_y  = read_en && (read_address == 3) && (yq.size() > 0);
    push_a = write_en && (write_address == 4) && (aq.size() < DEPTH);
    push_b = write_en && (write_address == 5) && (bq.size() < DEPTH);
    comp   = (aq.size() > 0) && (bq.size() > 0) && (yq.size() < DEPTH);
    if (pop_y) void'(yq.pop_front());
    if (comp) begin
      logic [DW-1:0] av, bv;
      av = aq.pop_front();
      bv = bq.pop_front();
      yq.push_back(av | bv);
      n_results++;
    end
    if (push_a) aq.push_back(write_data);
    if (push_b) bq.push_back(write_data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic          e_wrdy;
    logic          e_rrdy;
    logic [DW-1:0] e_rd;
    #1;
    e_wrdy = 1'b1;
    if (write_address == 4 && aq.size() == DEPTH) e_wrdy = 1'b0;
    if (write_address == 5 && bq.size() == DEPTH) e_wrdy = 1'b0;
    e_rrdy = 1'b1;
    e_rd   = '0;
    case (read_address)
      3'd0: e_rd = (aq.size() < DEPTH) ? 8'd1 : 8'd0;
      3'd1: e_rd = (bq.size() < DEPTH) ? 8'd1 : 8'd0;
      3'd2: e_rd = (yq.size() != 0) ? 8'd1 : 8'd0;
      3'd3: if (yq.size() == 0) e_rrdy = 1'b0; else e_rd = yq[0];
      default: e_rd = '0;
    endcase
    chk({tag, ".write_rdy"}, 32'(write_rdy), 32'(e_wrdy));
    chk({tag, ".read_data"}, 32'(read_data), 32'(e_rd));
    chk({tag, ".read_rdy"}, 32'(read_rdy), 32'(e_rrdy));
    chk({tag, ".counter"}, 32'(counter_out), 32'(exp_counter()));
    chk({tag, ".a_empty_n"}, 32'(a_ff_EMPTY_N), 32'(aq.size() != 0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic queue_three_pairs(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                   input logic [DW-1:0] a2, input logic [DW-1:0] b0,
                                   input logic [DW-1:0] b1, input logic [DW-1:0] b2);
    logic [DW-1:0] av[3];
    logic [DW-1:0] bv[3];
    av = '{a0, a1, a2};
    bv = '{b0, b1, b2};
    for (int k = 0; k < 3; k++) begin
      apply(3'd4, av[k], 1'b1, 3'd2, 1'b0);
      check_model("pairs.wr_a");
      tick();
      apply(3'd5, bv[k], 1'b1, 3'd2, 1'b0);
      check_model("pairs.wr_b");
      tick();
    end
    apply(0, 0, 0, 3'd2, 0);
    check_model("pairs.idle");
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] ra, input logic [DW-1:0] exp);
    apply(0, 0, 0, ra, 0);
    #1;
    chk(name, 32'(read_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] exp_pop[3];

    //              wa    wd     we    ra    re    wrdy  rdata  rrdy  cnt   aen
    vecs[0]  = '{3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 8'd0, 1'b0};
    vecs[1]  = '{3'd0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 8'h01, 1'b1, 8'd0, 1'b0};
    vecs[2]  = '{3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'd0, 1'b0};
    vecs[3]  = '{3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 8'd0, 1'b0};
    vecs[4]  = '{3'd0, 8'h00, 1'b0, 3'd6, 1'b0, 1'b1, 8'h00, 1'b1, 8'd0, 1'b0};
    vecs[5]  = '{3'd4, 8'h0F, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 8'd0, 1'b0};
    vecs[6]  = '{3'd5, 8'hF0, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 8'd0, 1'b1};
    vecs[7]  = '{3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'd0, 1'b1};
    vecs[8]  = '{3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 8'h01, 1'b1, 8'd1, 1'b0};
    vecs[9]  = '{3'd0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0};
    vecs[10] = '{3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0};
    vecs[11] = '{3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'd1, 1'b0};
    vecs[12] = '{3'd4, 8'h11, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 8'd1, 1'b0};
    vecs[13] = '{3'd4, 8'h22, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 8'd1, 1'b1};
    vecs[14] = '{3'd4, 8'h33, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd1, 1'b1};
    vecs[15] = '{3'd5, 8'h44, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b1, 8'd1, 1'b1};
    vecs[16] = '{3'd5, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'd1, 1'b1};
    vecs[17] = '{3'd5, 8'h88, 1'b1, 3'd3, 1'b0, 1'b1, 8'h55, 1'b1, 8'd2, 1'b1};
    vecs[18] = '{3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'h55, 1'b1, 8'd2, 1'b1};
    vecs[19] = '{3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'hAA, 1'b1, 8'd3, 1'b0};
    vecs[20] = '{3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'd3, 1'b0};

    do_reset();

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].wa, vecs[i].wd, vecs[i].we, vecs[i].ra, vecs[i].re);
      #1;
      $display("vec %0d: wa=%0d wd=0x%02h we=%0d ra=%0d re=%0d -> rdata=0x%02h rrdy=%0d wrdy=%0d cnt=%0d aen=%0d",
               i, vecs[i].wa, vecs[i].wd, vecs[i].we, vecs[i].ra, vecs[i].re,
               read_data, read_rdy, write_rdy, counter_out, a_ff_EMPTY_N);
      chk($sformatf("vec%0d.write_rdy", i), 32'(write_rdy), 32'(vecs[i].e_wrdy));
      chk($sformatf("vec%0d.read_data", i), 32'(read_data), 32'(vecs[i].e_rdata));
      chk($sformatf("vec%0d.read_rdy", i), 32'(read_rdy), 32'(vecs[i].e_rrdy));
      chk($sformatf("vec%0d.counter", i), 32'(counter_out), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.a_empty_n", i), 32'(a_ff_EMPTY_N), 32'(vecs[i].e_aen));
      tick();
    end

    // Three pairs with y_ff unpopped: two results fill y_ff, the third pair waits.
    do_reset();
    queue_three_pairs(8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40);
    apply(0, 0, 0, 3'd2, 0);
    #1;
    chk("wait.a_empty_n", 32'(a_ff_EMPTY_N), 32'd1);
    chk("wait.counter", 32'(counter_out), 32'd2);
    rd_chk("wait.y_status", 3'd2, 8'h01);
    exp_pop = '{8'h11, 8'h22, 8'h44};
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 3'd3, 1'b1);
      #1;
      $display("pop %0d: read_data=0x%02h read_rdy=%0d", k, read_data, read_rdy);
      chk($sformatf("order.pop%0d", k), 32'(read_data), 32'(exp_pop[k]));
      chk($sformatf("order.rdy%0d", k), 32'(read_rdy), 32'd1);
      tick();
    end
    rd_chk("order.y_empty", 3'd2, 8'h00);
    chk("order.counter", 32'(counter_out), 32'd3);

    // Reset with every FIFO occupied discards everything on that edge.
    queue_three_pairs(8'h81, 8'h82, 8'h84, 8'h08, 8'h04, 8'h02);
    apply(0, 0, 0, 3'd2, 0);
    #1;
    chk("prerst.a_empty_n", 32'(a_ff_EMPTY_N), 32'd1);
    chk("prerst.y_status", 32'(read_data), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_chk("rst.a_status", 3'd0, 8'h01);
    rd_chk("rst.b_status", 3'd1, 8'h01);
    rd_chk("rst.y_status", 3'd2, 8'h00);
    chk("rst.a_empty_n", 32'(a_ff_EMPTY_N), 32'd0);
    chk("rst.counter", 32'(counter_out), 32'd0);

    // 256 results: counter wraps to 0, or sticks at 0xFF when saturating.
    for (int i = 0; i < 256; i++) begin
      apply(3'd4, 8'(i), 1'b1, 3'd3, 1'b1);
      check_model("cnt.wr_a");
      tick();
      apply(3'd5, 8'(i * 3), 1'b1, 3'd3, 1'b1);
      check_model("cnt.wr_b");
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 3'd3, 1'b1);
      check_model("cnt.drain");
      tick();
    end
    apply(0, 0, 0, 3'd2, 0);
    #1;
`ifdef DUT_COUNTER_SAT_EN
    chk("cnt.after256", 32'(counter_out), 32'hFF);
`else
    chk("cnt.after256", 32'(counter_out), 32'h00);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : AW'(4 + $urandom_range(0, 1));
      ra = ($urandom_range(0, 1) == 0) ? 3'd3 : AW'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 63) != 0);
      apply(wa, DW'($urandom), 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)));
      check_model("rand");
      tick();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
